// File: rtl/sang_dan_pkg.sv
// -----------------------------------------------------------------------------
// sang_dan_pkg
// Shared constants and the LED pattern function for the 8-LED "fill then
// drain" chaser.
//   STEPS          : sequence length (one full fill + drain period)
//   FULL_STEP      : step index at which every LED is lit
//   LED_W          : number of LEDs driven
//   MODE_LSB_FIRST : MODE value that fills from out[0] upwards
//   MODE_MSB_FIRST : MODE value that fills from out[7] downwards
//   pattern()      : maps (step, mode) to the LED vector
// -----------------------------------------------------------------------------
package sang_dan_pkg;

  localparam int unsigned STEPS     = 16;
  localparam int unsigned FULL_STEP = 8;
  localparam int unsigned LED_W     = 8;
  localparam int unsigned STEP_W    = $clog2(STEPS);

  localparam logic MODE_LSB_FIRST = 1'b1;
  localparam logic MODE_MSB_FIRST = 1'b0;

  // Steps 0..FULL_STEP fill from bit 0 ((1<<s)-1); steps after FULL_STEP
  // drain from bit 0 (8'hFF << (s-FULL_STEP)). MSB-first mode is the
  // bit-reversed image of the same sequence.
  function automatic logic [LED_W-1:0] pattern(input logic [STEP_W-1:0] step,
                                               input logic              mode);
    logic [LED_W:0]   fill;
    logic [LED_W-1:0] base;
    logic [LED_W-1:0] rev;
    fill = '0;
    base = '0;
    rev  = '0;
    if (step <= STEP_W'(FULL_STEP)) begin
      // One extra bit so that step=FULL_STEP yields all ones after the -1.
      fill = ((LED_W+1)'(1) << step) - (LED_W+1)'(1);
      base = fill[LED_W-1:0];
    end else begin
      base = {LED_W{1'b1}} << (step - STEP_W'(FULL_STEP));
    end
    for (int i = 0; i < int'(LED_W); i++) begin
      rev[i] = base[int'(LED_W)-1-i];
    end
    return (mode == MODE_LSB_FIRST) ? base : rev;
  endfunction

endpackage : sang_dan_pkg

// File: rtl/sang_dan_tick.sv
// -----------------------------------------------------------------------------
// sang_dan_tick
// Step-rate divider. While enabled, counts TICK_DIV clocks per tick and
// emits a single-cycle tick on the last count. When disabled the count is
// frozen so that re-enabling resumes mid-period rather than restarting.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   en_i    : count enable (SS from the top)
//   tick_o  : one-cycle pulse, high in the cycle the counter wraps
// -----------------------------------------------------------------------------
module sang_dan_tick #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic             wrap;

  assign wrap   = (div_cnt_q == LAST_CNT);
  assign tick_o = en_i && wrap;

  always_comb begin
    // NOTE: assign every combinational output a default first; a path that
    // leaves it unassigned would infer a latch.
    div_cnt_d = div_cnt_q;
    if (en_i) begin
      div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule : sang_dan_tick

// File: rtl/sang_dan_led.sv
// -----------------------------------------------------------------------------
// sang_dan_led
// 8-LED fill-then-drain chaser. Each tick advances a 16-step counter and
// registers the matching LED pattern, so out always reflects the current
// step rendered in the MODE seen at the most recent tick.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; wins over SS and MODE
//   SS    : 1 = run, 0 = pause (step, out and divider all hold)
//   MODE  : 1 = fill from out[0], 0 = fill from out[7]
//   out   : registered LED drive, 1 = lit
// -----------------------------------------------------------------------------
module sang_dan_led
  import sang_dan_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SS,
  input  logic             MODE,
  output logic [LED_W-1:0] out
);

  logic              tick;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [LED_W-1:0]  out_q;
  logic [LED_W-1:0]  out_d;

  sang_dan_tick #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (SS),
    .tick_o (tick)
  );

  // MODE is only consulted here, on a tick; between ticks out is untouched,
  // and a mode change never restarts the step count.
  always_comb begin
    step_d = step_q;
    out_d  = out_q;
    if (tick) begin
      step_d = step_q + STEP_W'(1);   // wraps 15 -> 0 naturally
      out_d  = pattern(step_d, MODE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      out_q  <= '0;
    end else begin
      step_q <= step_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule : sang_dan_led

// File: tb/tb_sang_dan_led.sv
// -----------------------------------------------------------------------------
// tb_sang_dan_led
// Directed bench for sang_dan_led. Instance dut_a (TICK_DIV=1) is driven
// from a vector table; instance dut_b (TICK_DIV=4) runs a hand-written
// divider/pause sequence.
// -----------------------------------------------------------------------------
module tb_sang_dan_led;

  typedef struct {
    logic       reset;
    logic       ss;
    logic       mode;
    logic [7:0] exp_out;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1, ss_a = 1'b0, mode_a = 1'b1;
  logic       reset_b = 1'b1, ss_b = 1'b0, mode_b = 1'b1;
  logic [7:0] out_a, out_b;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sang_dan_led #(.TICK_DIV(1), .CNT_W(32)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .SS    (ss_a),
    .MODE  (mode_a),
    .out   (out_a)
  );

  sang_dan_led #(.TICK_DIV(4), .CNT_W(8)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .SS    (ss_b),
    .MODE  (mode_b),
    .out   (out_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ss, input logic mode, input logic [7:0] e);
    vec_t v;
    v.reset = r; v.ss = ss; v.mode = mode; v.exp_out = e;
    vecs.push_back(v);
  endtask

  task automatic add_run(input logic mode, input logic [7:0] e[]);
    foreach (e[i]) add(1'b0, 1'b1, mode, e[i]);
  endtask

  // Drive dut_b for one edge and check out_b #1 after it.
  task automatic step_b(input logic r, input logic ss, input logic [7:0] e, input string name);
    reset_b = r; ss_b = ss; mode_b = 1'b1;
    @(posedge clk); #1;
    check(name, out_b, e);
  endtask

  // Safety net: the bench must always end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Table for dut_a ---------------------------------------------------
    // 1: MODE=1 fill/drain, including wrap back to 00 then 01.
    add(1'b1, 1'b1, 1'b1, 8'h00);
    add_run(1'b1, '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01});
    // 2: MODE=0 full period.
    add(1'b1, 1'b1, 1'b0, 8'h00);
    add_run(1'b0, '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                    8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00});
    // 3: pause at 07 for 5 edges, resume to 0F.
    add(1'b1, 1'b1, 1'b1, 8'h00);
    add_run(1'b1, '{8'h01, 8'h03, 8'h07});
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 8'h07);
    add(1'b0, 1'b1, 1'b1, 8'h0F);
    // 4: MODE 1->0 at step 3: F0 then F8.
    add(1'b1, 1'b1, 1'b1, 8'h00);
    add_run(1'b1, '{8'h01, 8'h03, 8'h07});
    add_run(1'b0, '{8'hF0, 8'hF8});
    // 6: reset while at FC; restart at 01.
    add(1'b1, 1'b1, 1'b1, 8'h00);
    add_run(1'b1, '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC});
    add(1'b1, 1'b1, 1'b1, 8'h00);
    add_run(1'b1, '{8'h01, 8'h03});

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset_a = vecs[i].reset;
      ss_a    = vecs[i].ss;
      mode_a  = vecs[i].mode;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), out_a, vecs[i].exp_out);
      // After a reset edge the step counter itself must be back at 0.
      if (vecs[i].reset)
        check($sformatf("vec%0d_step", i), 8'(dut_a.step_q), 8'h00);
    end

    // ---- 5: dut_b with TICK_DIV=4 -----------------------------------------
    step_b(1'b1, 1'b1, 8'h00, "div4_reset");
    for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1, 8'h00, $sformatf("div4_hold00_%0d", i));
    step_b(1'b0, 1'b1, 8'h01, "div4_tick1");
    for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1, 8'h01, $sformatf("div4_hold01_%0d", i));
    step_b(1'b0, 1'b1, 8'h03, "div4_tick2");
    // Two counts into the next period, then pause.
    step_b(1'b0, 1'b1, 8'h03, "div4_cnt1");
    step_b(1'b0, 1'b1, 8'h03, "div4_cnt2");
    for (int i = 0; i < 3; i++) step_b(1'b0, 1'b0, 8'h03, $sformatf("div4_pause_%0d", i));
    // Resume: only two more edges remain in this period.
    step_b(1'b0, 1'b1, 8'h03, "div4_resume_cnt3");
    step_b(1'b0, 1'b1, 8'h07, "div4_resume_tick");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sang_dan_led
